// File: rtl/neuron_activation_pipe_if.sv
// Purpose : valid/ready bundle between the linear neuron, the activation stage and its consumer.
// Latency : n/a (wires only).
// Backpressure: in_ready/out_ready carry stall information upstream.
// Ports   : in_valid/in_ready/in_y/in_act_sel (request side), out_valid/out_ready/out_z (result side).
interface neuron_activation_pipe_if #(
    parameter int B = 16
);
    logic         in_valid;
    logic         in_ready;
    logic [B-1:0] in_y;
    logic         in_act_sel;
    logic         out_valid;
    logic         out_ready;
    logic [B-1:0] out_z;

    // master: the side that produces pre-activations and consumes results
    modport master (
        output in_valid, in_y, in_act_sel, out_ready,
        input  in_ready, out_valid, out_z
    );

    // slave: the activation stage itself
    modport slave (
        input  in_valid, in_y, in_act_sel, out_ready,
        output in_ready, out_valid, out_z
    );
endinterface

// File: rtl/neuron_activation_pipe.sv
// Purpose : ReLU / piecewise-linear sigmoid on a signed Q8.8 pre-activation, one result per cycle.
// Latency : accepted at edge k, result on out_z with out_valid after edge k+1 (two register stages).
// Backpressure: 2-entry skid-free pipeline, bubbles collapse; in_ready = !s1_valid || !s2_valid || out_ready.
// Ports   : clk, rst_n (async, active low), bus (neuron_activation_pipe_if.slave).
// Build   : define NEURON_SIGMOID_EN to include the sigmoid datapath; otherwise every transaction is ReLU.
module neuron_activation_pipe #(
    parameter int B = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    neuron_activation_pipe_if.slave  bus
);

    // Q8.8 constants
    localparam logic [B-1:0] MAG_MAX = {1'b0, {(B-1){1'b1}}};
    localparam logic [B-1:0] ONE     = 16'h0100;

    // ---------------- flow control ----------------
    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv       = !s2_valid || bus.out_ready;
    assign s1_adv       = !s1_valid || s2_adv;
    assign bus.in_ready = s1_adv;

    // ---------------- stage 1: magnitude and region ----------------
    logic [B-1:0] neg_y;
    logic [B-1:0] mag;

    assign neg_y = '0 - bus.in_y;
    // Negating 0x8000 wraps back to 0x8000; clamp it so the magnitude stays positive.
    assign mag   = !bus.in_y[B-1] ? bus.in_y :
                   (neg_y[B-1] ? MAG_MAX : neg_y);

    logic         s1_sign;
    logic [B-1:0] s1_a;

`ifdef NEURON_SIGMOID_EN
    logic [1:0] region;
    logic [1:0] s1_region;
    logic       s1_sel;

    always_comb begin
        if (mag < 16'h0100)      region = 2'd0;
        else if (mag < 16'h0260) region = 2'd1;
        else if (mag < 16'h0500) region = 2'd2;
        else                     region = 2'd3;
    end
`else
    logic sel_unused;
    assign sel_unused = bus.in_act_sel;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_sign   <= 1'b0;
            s1_a      <= '0;
`ifdef NEURON_SIGMOID_EN
            s1_region <= 2'd0;
            s1_sel    <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign   <= bus.in_y[B-1];
                s1_a      <= mag;
`ifdef NEURON_SIGMOID_EN
                s1_region <= region;
                s1_sel    <= bus.in_act_sel;
`endif
            end
        end
    end

    // ---------------- stage 2: shift/add and sign fold ----------------
    logic [B-1:0] relu_z;
    logic [B-1:0] z_next;

    // For a non-negative input the stored magnitude is the input itself.
    assign relu_z = s1_sign ? '0 : s1_a;

`ifdef NEURON_SIGMOID_EN
    logic [B-1:0] f_mag;
    logic [B-1:0] sig_z;

    always_comb begin
        case (s1_region)
            2'd0:    f_mag = (s1_a >> 2) + 16'h0080;
            2'd1:    f_mag = (s1_a >> 3) + 16'h00A0;
            2'd2:    f_mag = (s1_a >> 5) + 16'h00D8;
            default: f_mag = ONE;
        endcase
    end

    // f_mag never exceeds 1.0, so the fold cannot underflow.
    assign sig_z  = s1_sign ? (ONE - f_mag) : f_mag;
    assign z_next = s1_sel ? sig_z : relu_z;
`else
    assign z_next = relu_z;
`endif

    logic [B-1:0] s2_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_z     <= '0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_z <= z_next;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out_z     = s2_z;

endmodule
